mips_mc_ctrl: RTL
=================

# mips_mc_ctrl

Multi-cycle control unit for the next-generation MIPS core: replaces the single-cycle combinational controller with a Moore state machine that sequences each instruction over 3–5+ cycles through one shared ALU and one unified memory port. Adds a request/ready memory handshake with a wait-state watchdog, and a sticky trap state for illegal opcodes and bus timeouts. Sits between the instruction register (opcode/funct) and the datapath muxes/enables of the multi-cycle datapath.

## Interface
- WAIT_W, 4: watchdog counter width; timeout after 2^WAIT_W consecutive not-ready cycles.
- CNT_W, 32: performance counter width (only used with MC_PERF_CNT_EN).
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current request this cycle.
- PCWr, PCWrCond, IRWr, RegWr, MemReq, MemWe, IorD, ALUSrcA  out  1 each.
- ALUSrcB  out  2  (0 BusB, 1 const 4, 2 imm32, 3 imm32<<2); ExtOp  out  2  (0 zero, 1 sign, 2 lui).
- PCSrc  out  2  (0 ALU, 1 ALUOut, 2 jump addr, 3 BusA); RegDst  out  2  (0 rt, 1 rd, 2 r31).
- MemtoReg  out  2  (0 ALUOut, 1 MDR, 2 PC); ALUctr  out  4  package encoding.
- BrNe  out  1  inverts Zero for PCWrCond; Trap  out  1; TrapCause  out  2  (0 none, 1 illegal, 2 timeout).
- state  out  4  current state (debug); cyc_cnt, inst_cnt  out  CNT_W  performance counters.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP, JR, JAL, TRAP.
- IDLE: all outputs 0; next FETCH unconditionally.
- FETCH: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUctr=ADD, PCSrc=0; IRWr and PCWr asserted only in the cycle mem_ready=1; stay while mem_ready=0.
- DECODE: ALUSrcB=3, ExtOp=1, ALUctr=ADD (branch target into ALUOut). Dispatch: 100011/101011→MEMADR; 000000 funct 001000→JR, other R→EXEC_R; 000100/000101→BRANCH; 000010→JUMP; 000011→JAL; 001000/001101/001111→EXEC_I; else TRAP cause 1.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ExtOp=1, ADD; →MEMRD (lw) or MEMWR (sw).
- MEMRD: MemReq=1, IorD=1; →MEMWB on mem_ready. MEMWB: RegWr=1, RegDst=0, MemtoReg=1; →FETCH.
- MEMWR: MemReq=1, MemWe=1, IorD=1; →FETCH on mem_ready.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUctr from funct (add, sub, and, or, slt, sll); unknown funct→TRAP cause 1. →ALUWB with RegDst=1.
- EXEC_I: ALUSrcB=2; addi ExtOp=1 ADD, ori ExtOp=0 OR, lui ExtOp=2 OR; →ALUWB with RegDst=0. ALUWB: RegWr=1, MemtoReg=0; →FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, SUB, PCWrCond=1, PCSrc=1, BrNe=1 for 000101; →FETCH.
- JUMP: PCWr=1, PCSrc=2. JR: PCWr=1, PCSrc=3. JAL: RegWr=1, RegDst=2, MemtoReg=2, PCWr=1, PCSrc=2. All →FETCH.
- TRAP: Trap=1, TrapCause held, all write enables/MemReq 0; sticky until Reset.
- Watchdog: cleared on entry to FETCH/MEMRD/MEMWR and on mem_ready=1; increments each not-ready cycle; when all-ones and mem_ready=0, next state TRAP cause 2.

## Timing
- All outputs are Moore decodes of registered state (ALUctr/RegDst also from opcode/funct); no combinational path from mem_ready to outputs except IRWr/PCWr in FETCH.
- Reset assertion forces IDLE, counters and TrapCause to 0 immediately (async), mid-instruction included; no memory write completes after Reset falls.
- Zero-wait latencies: R/I-type 4 cycles, lw 5, sw 4, beq/bne/j/jr/jal 3. Each not-ready cycle adds one.
- WAIT_W=4: 16 consecutive low mem_ready cycles in a memory state → TRAP entered on the 17th edge; ready on the 16th cycle completes normally.

## Configuration
- MC_PERF_CNT_EN defined: cyc_cnt increments every cycle not in IDLE/TRAP; inst_cnt increments on each transition into FETCH from a non-IDLE state; both saturate at all-ones, clear on Reset.
- Undefined: no counter registers; cyc_cnt and inst_cnt tied to 0.

## Structure
- Package mips_mc_pkg: state enum, opcode/funct constants, ALUctr encodings (ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5), PCSrc/RegDst/MemtoReg/ALUSrcB/TrapCause constants.
- One sub-module: mc_watchdog (WAIT_W counter, clear/enable inputs, timeout output).

## Test plan
- add (op 000000, funct 100000), mem_ready=1 → FETCH,DECODE,EXEC_R,ALUWB; RegWr=1, RegDst=1 in cycle 4 only; inst_cnt=1.
- lw, mem_ready low 3 cycles in MEMRD → MemReq/IorD held 4 cycles, MEMWB reached, total 8 cycles, RegWr once.
- bne with Zero=0 → BRANCH asserts PCWrCond=1, BrNe=1, PCSrc=1; back in FETCH after 3 cycles.
- sw with mem_ready stuck low, WAIT_W=4 → TRAP after 16 wait cycles, TrapCause=2, MemWe drops to 0, Trap stays 1 for 50 more cycles.
- opcode 111111 → TRAP from DECODE, TrapCause=1, no RegWr/PCWr ever asserted.
- Reset low mid-MEMWR → all outputs 0 same cycle, state=IDLE; release → FETCH on next edge, counters 0.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, functs,
// ALU operations, datapath mux selects and trap causes.
package mips_mc_pkg;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC_R = 4'd7;
    localparam logic [3:0] S_EXEC_I = 4'd8;
    localparam logic [3:0] S_ALUWB  = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JR     = 4'd12;
    localparam logic [3:0] S_JAL    = 4'd13;
    localparam logic [3:0] S_TRAP   = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5
    } alu_op_e;

    localparam logic [1:0] SRCB_BUSB   = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_BUSA   = 2'd3;

    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic       ir_wr;
        logic       reg_wr;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] ext_op;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [3:0] alu_ctr;
        logic       br_ne;
    } ctrl_t;

    function automatic logic funct_known(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT) || (funct == FN_SLL);
    endfunction

    function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            FN_SLL:  return ALU_SLL;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_watchdog.sv
// Memory wait-state watchdog: counts consecutive not-ready cycles and flags the
// cycle in which the count is saturated while the memory is still not ready.
module mc_watchdog #(
    parameter int WAIT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);
    localparam logic [WAIT_W-1:0] ONE = WAIT_W'(1);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + ONE;
        end
    end

    assign timeout = enable & (&count);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute over a
// shared ALU and memory port. Optional performance counters under MC_PERF_CNT_EN.
module mips_mc_ctrl
    import mips_mc_pkg::*;
#(
    parameter int WAIT_W = 4,
    parameter int CNT_W  = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWr,
    output logic             PCWrCond,
    output logic             IRWr,
    output logic             RegWr,
    output logic             MemReq,
    output logic             MemWe,
    output logic             IorD,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ExtOp,
    output logic [1:0]       PCSrc,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [3:0]       ALUctr,
    output logic             BrNe,
    output logic             Trap,
    output logic [1:0]       TrapCause,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] inst_cnt
);
    logic [3:0] cur_state;
    logic [3:0] next_state;
    logic [1:0] next_cause;
    logic [1:0] trap_cause;
    logic       mem_state;
    logic       wd_timeout;
    ctrl_t      ctrl;

    assign mem_state = (cur_state == S_FETCH) || (cur_state == S_MEMRD) ||
                       (cur_state == S_MEMWR);

    // Counter is held at zero outside memory states, so every entry starts fresh.
    mc_watchdog #(.WAIT_W(WAIT_W)) u_watchdog (
        .clk     (Clk),
        .rst_n   (Reset),
        .clear   (~mem_state | mem_ready),
        .enable  (mem_state & ~mem_ready),
        .timeout (wd_timeout)
    );

    always_comb begin
        next_state = cur_state;
        next_cause = CAUSE_NONE;
        case (cur_state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    next_state = S_DECODE;
                end else if (wd_timeout) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:             next_state = S_MEMADR;
                    OP_RTYPE:                 next_state = (funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_BEQ, OP_BNE:           next_state = S_BRANCH;
                    OP_J:                     next_state = S_JUMP;
                    OP_JAL:                   next_state = S_JAL;
                    OP_ADDI, OP_ORI, OP_LUI:  next_state = S_EXEC_I;
                    default: begin
                        next_state = S_TRAP;
                        next_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end else if (wd_timeout) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    next_state = S_FETCH;
                end else if (wd_timeout) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_EXEC_R: begin
                if (funct_known(funct)) begin
                    next_state = S_ALUWB;
                end else begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_ILLEGAL;
                end
            end
            S_EXEC_I: next_state = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_JR, S_JAL: next_state = S_FETCH;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cur_state  <= S_IDLE;
            trap_cause <= CAUSE_NONE;
        end else begin
            cur_state <= next_state;
            if ((next_state == S_TRAP) && (cur_state != S_TRAP)) begin
                trap_cause <= next_cause;
            end
        end
    end

    // Only IRWr/PCWr in FETCH look at mem_ready; everything else decodes state.
    always_comb begin
        ctrl = '0;
        case (cur_state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_ctr   = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
                ctrl.ir_wr     = mem_ready;
                ctrl.pc_wr     = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.ext_op    = EXT_SIGN;
                ctrl.alu_ctr   = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = EXT_SIGN;
                ctrl.alu_ctr   = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_wr     = 1'b1;
                ctrl.reg_dst    = DST_RT;
                ctrl.mem_to_reg = M2R_MDR;
            end
            S_MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_BUSB;
                ctrl.alu_ctr   = funct_to_alu(funct);
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_ORI: begin
                        ctrl.ext_op  = EXT_ZERO;
                        ctrl.alu_ctr = ALU_OR;
                    end
                    OP_LUI: begin
                        ctrl.ext_op  = EXT_LUI;
                        ctrl.alu_ctr = ALU_OR;
                    end
                    default: begin
                        ctrl.ext_op  = EXT_SIGN;
                        ctrl.alu_ctr = ALU_ADD;
                    end
                endcase
            end
            S_ALUWB: begin
                ctrl.reg_wr     = 1'b1;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.reg_dst    = (opcode == OP_RTYPE) ? DST_RD : DST_RT;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_BUSB;
                ctrl.alu_ctr    = ALU_SUB;
                ctrl.pc_wr_cond = 1'b1;
                ctrl.pc_src     = PC_ALUOUT;
                ctrl.br_ne      = (opcode == OP_BNE);
            end
            S_JUMP: begin
                ctrl.pc_wr  = 1'b1;
                ctrl.pc_src = PC_JUMP;
            end
            S_JR: begin
                ctrl.pc_wr  = 1'b1;
                ctrl.pc_src = PC_BUSA;
            end
            S_JAL: begin
                ctrl.reg_wr     = 1'b1;
                ctrl.reg_dst    = DST_R31;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.pc_wr      = 1'b1;
                ctrl.pc_src     = PC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

    assign PCWr      = ctrl.pc_wr;
    assign PCWrCond  = ctrl.pc_wr_cond;
    assign IRWr      = ctrl.ir_wr;
    assign RegWr     = ctrl.reg_wr;
    assign MemReq    = ctrl.mem_req;
    assign MemWe     = ctrl.mem_we;
    assign IorD      = ctrl.iord;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ExtOp     = ctrl.ext_op;
    assign PCSrc     = ctrl.pc_src;
    assign RegDst    = ctrl.reg_dst;
    assign MemtoReg  = ctrl.mem_to_reg;
    assign ALUctr    = ctrl.alu_ctr;
    assign BrNe      = ctrl.br_ne;
    assign Trap      = (cur_state == S_TRAP);
    assign TrapCause = trap_cause;
    assign state     = cur_state;

`ifdef MC_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] inst_q;
    logic             inst_done;

    // Retirement is any return to FETCH except the initial IDLE->FETCH step.
    assign inst_done = (next_state == S_FETCH) && (cur_state != S_FETCH) &&
                       (cur_state != S_IDLE);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cyc_q  <= '0;
            inst_q <= '0;
        end else begin
            if ((cur_state != S_IDLE) && (cur_state != S_TRAP) && (cyc_q != '1)) begin
                cyc_q <= cyc_q + CNT_ONE;
            end
            if (inst_done && (inst_q != '1)) begin
                inst_q <= inst_q + CNT_ONE;
            end
        end
    end

    assign cyc_cnt  = cyc_q;
    assign inst_cnt = inst_q;
`else
    assign cyc_cnt  = '0;
    assign inst_cnt = '0;
`endif

endmodule
